coffee_dispense_sequencer: RTL and testbench

//  Sequences the ingredient valves (Coffee/Water/Cream/Sugar) for one drink per request.

---
 rtl/coffee_dispense_sequencer.sv | 166 ++++++++++++++++
 tb/tb_coffee_dispense_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coffee_dispense_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : coffee_dispense_sequencer                                        |
// | Brief   : Opens the coffee/water/cream/sugar valves in a fixed order for   |
// |           one drink per request and counts completed drinks.               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module coffee_dispense_sequencer #(
  parameter int T_COFFEE = 4,
  parameter int T_WATER  = 6,
  parameter int T_CREAM  = 3,
  parameter int T_SUGAR  = 2,
  parameter int CNT_W    = 8
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Req_Valid,
  input  logic [1:0]       Req_Drink,
  output logic             Req_Ready,
  input  logic             Abort,
  output logic             Coffee,
  output logic             Water,
  output logic             Cream,
  output logic             Sugar,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Drink_Count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COFFEE = 3'd1,
    S_WATER  = 3'd2,
    S_CREAM  = 3'd3,
    S_SUGAR  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [7:0] c_t_coffee = 8'(T_COFFEE);
  localparam logic [7:0] c_t_water  = 8'(T_WATER);
  localparam logic [7:0] c_t_cream  = 8'(T_CREAM);
  localparam logic [7:0] c_t_sugar  = 8'(T_SUGAR);

  state_t           r_state;
  state_t           w_next_state;
  logic [7:0]       r_timer;
  logic [7:0]       w_next_timer;
  logic [1:0]       r_drink;
  logic [CNT_W-1:0] r_count;
  logic             w_accept;
  logic             w_phase_end;
  logic             w_enter_done;

  assign w_accept    = (r_state == S_IDLE) && Req_Valid && (Req_Drink != 2'd0);
  assign w_phase_end = (r_timer == 8'd1);

  // Timer holds the cycles left in the current valve phase; the phase ends
  // on the edge where it reads 1, so each phase lasts exactly its load value.
  always_comb begin
    w_next_state = r_state;
    w_next_timer = r_timer;
    case (r_state)
      S_IDLE: begin
        w_next_timer = 8'd0;
        if (w_accept) begin
          w_next_state = S_COFFEE;
          w_next_timer = c_t_coffee;
        end
      end
      S_COFFEE: begin
        if (Abort) begin
          w_next_state = S_IDLE;
          w_next_timer = 8'd0;
        end else if (w_phase_end) begin
          w_next_state = S_WATER;
          w_next_timer = c_t_water;
        end else begin
          w_next_timer = r_timer - 8'd1;
        end
      end
      S_WATER: begin
        if (Abort) begin
          w_next_state = S_IDLE;
          w_next_timer = 8'd0;
        end else if (w_phase_end) begin
          if (r_drink >= 2'd2) begin
            w_next_state = S_CREAM;
            w_next_timer = c_t_cream;
          end else begin
            w_next_state = S_DONE;
            w_next_timer = 8'd0;
          end
        end else begin
          w_next_timer = r_timer - 8'd1;
        end
      end
      S_CREAM: begin
        if (Abort) begin
          w_next_state = S_IDLE;
          w_next_timer = 8'd0;
        end else if (w_phase_end) begin
          if (r_drink == 2'd3) begin
            w_next_state = S_SUGAR;
            w_next_timer = c_t_sugar;
          end else begin
            w_next_state = S_DONE;
            w_next_timer = 8'd0;
          end
        end else begin
          w_next_timer = r_timer - 8'd1;
        end
      end
      S_SUGAR: begin
        if (Abort) begin
          w_next_state = S_IDLE;
          w_next_timer = 8'd0;
        end else if (w_phase_end) begin
          w_next_state = S_DONE;
          w_next_timer = 8'd0;
        end else begin
          w_next_timer = r_timer - 8'd1;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
        w_next_timer = 8'd0;
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_timer = 8'd0;
      end
    endcase
  end

  assign w_enter_done = (w_next_state == S_DONE) && (r_state != S_DONE);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_IDLE;
      r_timer <= 8'd0;
      r_drink <= 2'd0;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_timer <= w_next_timer;
      if (w_accept) begin
        r_drink <= Req_Drink;
      end
      // Saturate rather than wrap once every bit is set.
      if (w_enter_done && (r_count != {CNT_W{1'b1}})) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign Req_Ready   = (r_state == S_IDLE);
  assign Busy        = (r_state != S_IDLE);
  assign Done        = (r_state == S_DONE);
  assign Coffee      = (r_state == S_COFFEE);
  assign Water       = (r_state == S_WATER);
  assign Cream       = (r_state == S_CREAM);
  assign Sugar       = (r_state == S_SUGAR);
  assign Drink_Count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_coffee_dispense_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_coffee_dispense_sequencer                                     |
// | Brief   : Scoreboard bench for the drink sequencer: each issued drink      |
// |           queues its expected valve/Done/count outcome for the monitor.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_coffee_dispense_sequencer;

  localparam int TC  = 4;
  localparam int TW  = 6;
  localparam int TCR = 3;
  localparam int TS  = 2;
  localparam int CW  = 8;

  logic          Clock = 1'b0;
  logic          nReset = 1'b0;
  logic          Req_Valid = 1'b0;
  logic [1:0]    Req_Drink = 2'd0;
  logic          Abort = 1'b0;
  logic          Req_Ready, Coffee, Water, Cream, Sugar, Busy, Done;
  logic [CW-1:0] Drink_Count;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int model_cnt = 0;
  int rise_last = 0;
  int rise_prev = 0;

  typedef struct {
    int c; int w; int cr; int s; int len; int done; int count;
  } exp_t;
  exp_t sb_q[$];

  coffee_dispense_sequencer #(
    .T_COFFEE(TC), .T_WATER(TW), .T_CREAM(TCR), .T_SUGAR(TS), .CNT_W(CW)
  ) dut (
    .Clock(Clock), .nReset(nReset), .Req_Valid(Req_Valid), .Req_Drink(Req_Drink),
    .Req_Ready(Req_Ready), .Abort(Abort), .Coffee(Coffee), .Water(Water),
    .Cream(Cream), .Sugar(Sugar), .Busy(Busy), .Done(Done), .Drink_Count(Drink_Count)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    cyc <= cyc + 1;
    if (cyc > 60000) begin
      $display("FAIL watchdog: got %0d cycles, required completion below 60000", cyc);
      $fatal(1);
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Outcome of one drink from the phase list; k>0 means Abort held during
  // busy cycle k, which only truncates the drink if it falls in a valve phase.
  function automatic exp_t model(input int d, input int k, input int cnt_before);
    int   dur[4];
    int   op[4];
    int   total;
    int   rem;
    exp_t e;
    dur[0] = TC;
    dur[1] = TW;
    dur[2] = (d >= 2) ? TCR : 0;
    dur[3] = (d == 3) ? TS : 0;
    total = dur[0] + dur[1] + dur[2] + dur[3];
    if (k == 0 || k > total) begin
      op = dur;
      e.len = total + 1;
      e.done = 1;
      e.count = (cnt_before >= 255) ? 255 : cnt_before + 1;
    end else begin
      rem = k;
      for (int i = 0; i < 4; i++) begin
        op[i] = (dur[i] < rem) ? dur[i] : rem;
        rem -= op[i];
      end
      e.len = k;
      e.done = 0;
      e.count = cnt_before;
    end
    e.c = op[0]; e.w = op[1]; e.cr = op[2]; e.s = op[3];
    return e;
  endfunction

  function automatic int drink_total(input int d);
    return TC + TW + ((d >= 2) ? TCR : 0) + ((d == 3) ? TS : 0);
  endfunction

  // Monitor: accumulates each busy episode and compares it when Busy falls.
  initial begin : monitor
    int   c, w, cr, s, len, dn, last_v, v;
    bit   pb;
    bit   order_ok;
    exp_t e;
    pb = 1'b0;
    c = 0; w = 0; cr = 0; s = 0; len = 0; dn = 0; last_v = 0; order_ok = 1'b1;
    forever begin
      @(negedge Clock);
      check("valve_exclusive",
            ($countones({Coffee, Water, Cream, Sugar}) <= 1) &&
            (Busy || !(Coffee | Water | Cream | Sugar | Done)), 1);
      if (Busy && !pb) begin
        c = 0; w = 0; cr = 0; s = 0; len = 0; dn = 0; last_v = 0; order_ok = 1'b1;
        rise_prev = rise_last;
        rise_last = cyc;
      end
      if (Busy) begin
        len++;
        c += int'(Coffee); w += int'(Water); cr += int'(Cream); s += int'(Sugar);
        dn += int'(Done);
        v = Coffee ? 1 : Water ? 2 : Cream ? 3 : Sugar ? 4 : Done ? 5 : 0;
        if (v != 0) begin
          if (v < last_v) order_ok = 1'b0;
          last_v = v;
        end
      end
      if (!Busy && pb) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_episode: got a busy episode of %0d cycles, expected none", len);
        end else begin
          e = sb_q.pop_front();
          check("coffee_cycles", c, e.c);
          check("water_cycles", w, e.w);
          check("cream_cycles", cr, e.cr);
          check("sugar_cycles", s, e.s);
          check("busy_length", len, e.len);
          check("done_pulses", dn, e.done);
          check("phase_order", order_ok, 1);
          check("drink_count", Drink_Count, e.count);
        end
      end
      pb = Busy;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!Req_Ready && n < 200) begin
      @(posedge Clock); #1;
      n++;
    end
    if (!Req_Ready) begin
      n_total++;
      $display("FAIL wait_ready: got Req_Ready=0, expected 1 within 200 cycles");
    end
  endtask

  task automatic run_drink(input int d, input int k, input bit ab);
    exp_t e;
    wait_ready();
    Req_Valid = 1'b1;
    Req_Drink = 2'(d);
    Abort = ab;
    @(posedge Clock); #1;
    Req_Valid = 1'b0;
    Abort = 1'b0;
    Req_Drink = 2'($urandom_range(0, 3));
    e = model(d, k, model_cnt);
    sb_q.push_back(e);
    model_cnt = e.count;
    if (k > 0) begin
      repeat (k - 1) begin @(posedge Clock); #1; end
      Abort = 1'b1;
      @(posedge Clock); #1;
      Abort = 1'b0;
    end
  endtask

  initial begin : stim
    exp_t e;
    int   d, k;

    repeat (3) @(posedge Clock);
    #1;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_valves", {Coffee, Water, Cream, Sugar}, 0);
    check("rst_count", Drink_Count, 0);
    nReset = 1'b1;
    @(posedge Clock); #1;
    check("rst_ready", Req_Ready, 1);

    run_drink(1, 0, 1'b0);
    run_drink(3, 0, 1'b0);

    run_drink(1, 7, 1'b0);
    check("ready_after_abort", Req_Ready, 1);
    run_drink(2, 0, 1'b1);
    check("busy_after_reaccept", Busy, 1);

    wait_ready();
    Req_Valid = 1'b1;
    Req_Drink = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clock); #1;
      check("zero_drink_busy", Busy, 0);
      check("zero_drink_ready", Req_Ready, 1);
    end

    Req_Drink = 2'd2;
    @(posedge Clock); #1;
    e = model(2, 0, model_cnt); sb_q.push_back(e); model_cnt = e.count;
    wait_ready();
    @(posedge Clock); #1;
    e = model(2, 0, model_cnt); sb_q.push_back(e); model_cnt = e.count;
    Req_Valid = 1'b0;
    @(negedge Clock); #1;
    check("b2b_spacing", rise_last - rise_prev, 15);

    wait_ready();
    Req_Valid = 1'b1;
    Req_Drink = 2'd2;
    @(posedge Clock); #1;
    Req_Valid = 1'b0;
    repeat (11) begin @(posedge Clock); #1; end
    check("pre_reset_cream", Cream, 1);
    e = model(2, 11, model_cnt);
    e.count = 0;
    sb_q.push_back(e);
    model_cnt = 0;
    nReset = 1'b0;
    #1;
    check("async_rst_busy", Busy, 0);
    check("async_rst_valves", {Coffee, Water, Cream, Sugar}, 0);
    check("async_rst_done", Done, 0);
    check("async_rst_count", Drink_Count, 0);
    @(posedge Clock); #1;
    nReset = 1'b1;
    @(posedge Clock); #1;
    check("ready_after_reset", Req_Ready, 1);
    run_drink(2, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      d = $urandom_range(1, 3);
      k = ($urandom_range(0, 2) == 0) ? $urandom_range(1, drink_total(d) + 1) : 0;
      run_drink(d, k, 1'($urandom_range(0, 1)));
    end

    while (model_cnt < 254) run_drink(1, 0, 1'b0);
    run_drink($urandom_range(1, 3), 0, 1'b0);
    run_drink($urandom_range(1, 3), 0, 1'b0);

    wait_ready();
    repeat (3) @(negedge Clock);
    check("scoreboard_drained", sb_q.size(), 0);
    check("final_count", Drink_Count, 255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
